// File: rtl/fan_ctrl_mc.sv
// Multi-channel fan controller: a shared PWM timebase drives NCH phase-aligned PWM
// outputs, with a per-channel spin-up kick, tach period meter and stall flag.
module fan_ctrl_mc #(
    parameter int unsigned NCH       = 2,
    parameter int unsigned PWM_BITS  = 8,
    parameter int unsigned PRESCALE  = 16,
    parameter int unsigned MEAS_BITS = 20,
    parameter int unsigned KICK_MS   = 500
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tsc_1ppms,
    input  logic                     tsc_1ppus,
    input  logic [NCH-1:0]           fan_en,
    input  logic [NCH*PWM_BITS-1:0]  fan_pct,
    input  logic [NCH-1:0]           fan_tach,
    output logic [NCH-1:0]           fan_pwm,
    output logic [NCH*MEAS_BITS-1:0] fan_uspr,
    output logic [NCH-1:0]           fan_stall
);

    localparam int unsigned PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned KICK_W = (KICK_MS > 0) ? $clog2(KICK_MS + 1) : 1;
    localparam logic [PS_W-1:0]      PS_LAST   = PS_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0]  PWM_MAX   = {PWM_BITS{1'b1}};
    localparam logic [MEAS_BITS-1:0] MEAS_MAX  = {MEAS_BITS{1'b1}};
    localparam logic [MEAS_BITS-1:0] MEAS_ONE  = MEAS_BITS'(1);
    localparam logic [KICK_W-1:0]    KICK_LOAD = KICK_W'(KICK_MS);
    localparam bit                   KICK_ON   = (KICK_MS > 0);

    // Shared timebase
    logic [PS_W-1:0]     r_presc;
    logic [PWM_BITS-1:0] r_cnt;
    logic                w_pwm_ce;
    logic                w_wrap;

    // Per-channel PWM state
    logic [PWM_BITS-1:0] r_duty [NCH];
    logic [KICK_W-1:0]   r_kick [NCH];
    logic [NCH-1:0]      r_en_q;
    logic [NCH-1:0]      r_pwm;
    logic [NCH-1:0]      w_rise;
    logic [NCH-1:0]      w_raw;

    // Per-channel tach state
    logic [NCH-1:0]       r_sync1;
    logic [NCH-1:0]       r_sync2;
    logic [NCH-1:0]       r_d1;
    logic [NCH-1:0]       r_d2;
    logic [NCH-1:0]       r_pulse;
    logic [NCH-1:0]       r_armed;
    logic [NCH-1:0]       r_stall;
    logic [MEAS_BITS-1:0] r_meas [NCH];
    logic [MEAS_BITS-1:0] r_idle [NCH];
    logic [MEAS_BITS-1:0] r_uspr [NCH];

    assign w_pwm_ce = (r_presc == PS_LAST);
    assign w_wrap   = w_pwm_ce && (r_cnt == PWM_MAX);

    // Prescaler and shared PWM counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_cnt   <= '0;
        end else if (w_pwm_ce) begin
            r_presc <= '0;
            r_cnt   <= r_cnt + PWM_BITS'(1);
        end else begin
            r_presc <= r_presc + PS_W'(1);
        end
    end

    // Raw PWM: kick (including the enable edge itself) forces high; all-ones duty never dips
    always_comb begin
        w_rise = fan_en & ~r_en_q;
        w_raw  = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            w_raw[i] = fan_en[i] && ((r_kick[i] != '0) || (w_rise[i] && KICK_ON) ||
                                     (r_duty[i] == PWM_MAX) || (r_cnt < r_duty[i]));
        end
    end

    // Duty latch at period end, kick countdown, registered PWM output
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_q <= '0;
            r_pwm  <= '0;
            for (int i = 0; i < int'(NCH); i++) begin
                r_duty[i] <= '0;
                r_kick[i] <= '0;
            end
        end else begin
            r_en_q <= fan_en;
            r_pwm  <= w_raw;
            for (int i = 0; i < int'(NCH); i++) begin
                if (w_wrap) begin
                    r_duty[i] <= fan_pct[i*PWM_BITS +: PWM_BITS];
                end
                if (!fan_en[i]) begin
                    r_kick[i] <= '0;
                end else if (w_rise[i]) begin
                    r_kick[i] <= KICK_LOAD;
                end else if (tsc_1ppms && (r_kick[i] != '0)) begin
                    r_kick[i] <= r_kick[i] - KICK_W'(1);
                end
            end
        end
    end

    // Tach synchroniser, us-tick edge detect and period measurement
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_d1    <= '0;
            r_d2    <= '0;
            r_pulse <= '0;
            r_armed <= '0;
            r_stall <= '0;
            for (int i = 0; i < int'(NCH); i++) begin
                r_meas[i] <= '0;
                r_idle[i] <= '0;
                r_uspr[i] <= '0;
            end
        end else begin
            r_sync1 <= fan_tach;
            r_sync2 <= r_sync1;
            for (int i = 0; i < int'(NCH); i++) begin
                if (!fan_en[i]) begin
                    r_d1[i]    <= 1'b0;
                    r_d2[i]    <= 1'b0;
                    r_pulse[i] <= 1'b0;
                    r_armed[i] <= 1'b0;
                    r_stall[i] <= 1'b0;
                    r_meas[i]  <= '0;
                    r_idle[i]  <= '0;
                    r_uspr[i]  <= '0;
                end else if (tsc_1ppus) begin
                    r_d1[i]    <= r_sync2[i];
                    r_d2[i]    <= r_d1[i];
                    r_pulse[i] <= r_d1[i] & ~r_d2[i];
                    if (r_pulse[i]) begin
                        // First edge only arms; later edges publish the period
                        if (r_armed[i]) begin
                            r_uspr[i]  <= r_meas[i];
                            r_stall[i] <= 1'b0;
                        end
                        r_meas[i]  <= MEAS_ONE;
                        r_armed[i] <= 1'b1;
                        r_idle[i]  <= '0;
                    end else if (r_armed[i]) begin
                        if (r_meas[i] == MEAS_MAX) begin
                            // Disarm so recovery needs two fresh edges to clear the stall
                            r_uspr[i]  <= MEAS_MAX;
                            r_stall[i] <= 1'b1;
                            r_armed[i] <= 1'b0;
                            r_meas[i]  <= '0;
                        end else begin
                            r_meas[i] <= r_meas[i] + MEAS_ONE;
                        end
                    end else if (r_idle[i] == MEAS_MAX) begin
                        r_uspr[i]  <= MEAS_MAX;
                        r_stall[i] <= 1'b1;
                    end else begin
                        r_idle[i] <= r_idle[i] + MEAS_ONE;
                    end
                end
            end
        end
    end

    // Output packing
    always_comb begin
        fan_uspr = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            fan_uspr[i*MEAS_BITS +: MEAS_BITS] = r_uspr[i];
        end
    end

    assign fan_pwm   = r_pwm;
    assign fan_stall = r_stall;

endmodule
